// File: rtl/ball_collision_array.sv
// Elastic equal-mass collision resolver for NUM_BALLS balls: detects overlapping
// pairs from draw requests and resolves the pending pairs one at a time once per frame.
module ball_collision_array #(
    parameter int NUM_BALLS     = 4,
    parameter int COORD_W       = 11,
    parameter int VEL_W         = 11,
    parameter int BALL_DIAMETER = 32
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic [NUM_BALLS-1:0]           ballDR,
    input  logic [NUM_BALLS*COORD_W-1:0]   ballPosX,
    input  logic [NUM_BALLS*COORD_W-1:0]   ballPosY,
    input  logic [NUM_BALLS*VEL_W-1:0]     ballVelX,
    input  logic [NUM_BALLS*VEL_W-1:0]     ballVelY,
    output logic [NUM_BALLS*VEL_W-1:0]     ballVelXOut,
    output logic [NUM_BALLS*VEL_W-1:0]     ballVelYOut,
    output logic                           velValid,
    output logic [NUM_BALLS-1:0]           collisionMask,
    output logic                           busy
);

    localparam int P     = NUM_BALLS * (NUM_BALLS - 1) / 2;
    localparam int K_W   = (P > 1) ? $clog2(P) : 1;
    localparam int I_W   = $clog2(NUM_BALLS);
    localparam int NUM_W = 2 * (COORD_W + 1) + VEL_W + 3;
    localparam int C_W   = $clog2(NUM_W);
    localparam logic [COORD_W:0] DIAM = (COORD_W + 1)'(BALL_DIAMETER);
    localparam logic signed [NUM_W-1:0] VMAX = {{(NUM_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
    localparam logic signed [NUM_W-1:0] VMIN = {{(NUM_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LOAD, S_MUL, S_DIV, S_WRITE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [I_W-1:0]             ci_q, ci_d, cj_q, cj_d;
    logic [P-1:0]               armed_q, armed_d, pending_q, pending_d;
    logic [NUM_BALLS-1:0]       mask_q, mask_d;
    logic signed [VEL_W-1:0]    vx_q [NUM_BALLS];
    logic signed [VEL_W-1:0]    vx_d [NUM_BALLS];
    logic signed [VEL_W-1:0]    vy_q [NUM_BALLS];
    logic signed [VEL_W-1:0]    vy_d [NUM_BALLS];
    logic signed [COORD_W:0]    dx_q, dx_d, dy_q, dy_d;
    logic signed [VEL_W-1:0]    v1x_q, v1x_d, v1y_q, v1y_d, v2x_q, v2x_d, v2y_q, v2y_d;
    logic [NUM_W-1:0]           div_q, div_d;
    logic [NUM_W-1:0]           num_q [4];
    logic [NUM_W-1:0]           num_d [4];
    logic [NUM_W:0]             rem_q [4];
    logic [NUM_W:0]             rem_d [4];
    logic [3:0]                 neg_q, neg_d;
    logic [C_W-1:0]             cnt_q, cnt_d;

    logic [COORD_W-1:0]         pos_x [NUM_BALLS];
    logic [COORD_W-1:0]         pos_y [NUM_BALLS];
    logic signed [VEL_W-1:0]    vel_in_x [NUM_BALLS];
    logic signed [VEL_W-1:0]    vel_in_y [NUM_BALLS];
    logic [P-1:0]               far_w, hit_w;

    for (genvar b = 0; b < NUM_BALLS; b++) begin : g_unpack
        assign pos_x[b]    = ballPosX[b*COORD_W +: COORD_W];
        assign pos_y[b]    = ballPosY[b*COORD_W +: COORD_W];
        assign vel_in_x[b] = ballVelX[b*VEL_W +: VEL_W];
        assign vel_in_y[b] = ballVelY[b*VEL_W +: VEL_W];
        assign ballVelXOut[b*VEL_W +: VEL_W] = vx_q[b];
        assign ballVelYOut[b*VEL_W +: VEL_W] = vy_q[b];
    end

    // Pair k = (gi,gj) in lexicographic order over gi < gj.
    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_BALLS; gj++) begin : g_col
            localparam int K = gi * NUM_BALLS - gi * (gi + 1) / 2 + (gj - gi - 1);
            logic signed [COORD_W:0] pdx, pdy;
            logic [COORD_W:0]        adx, ady;
            assign pdx      = $signed({1'b0, pos_x[gj]}) - $signed({1'b0, pos_x[gi]});
            assign pdy      = $signed({1'b0, pos_y[gj]}) - $signed({1'b0, pos_y[gi]});
            assign adx      = pdx[COORD_W] ? -pdx : pdx;
            assign ady      = pdy[COORD_W] ? -pdy : pdy;
            assign far_w[K] = (adx >= DIAM) || (ady >= DIAM);
            assign hit_w[K] = ballDR[gi] && ballDR[gj];
        end
    end

    // Detection wins over re-arm; a pair is consumed from pending when loaded.
    always_comb begin
        armed_d   = armed_q;
        pending_d = pending_q;
        if (state_q == S_LOAD) pending_d[k_q] = 1'b0;
        for (int k = 0; k < P; k++) begin
            if (far_w[k]) armed_d[k] = 1'b1;
            if (hit_w[k] && armed_q[k]) begin
                pending_d[k] = 1'b1;
                armed_d[k]   = 1'b0;
            end
        end
    end

    // Exchange normal components, keep tangential ones, all scaled by n2.
    logic signed [NUM_W-1:0] sdx, sdy, tx, ty, sv1x, sv1y, sv2x, sv2y;
    logic signed [NUM_W-1:0] p1, p2, t1, t2, n2_w;
    logic signed [NUM_W-1:0] numw [4];

    always_comb begin
        sdx     = NUM_W'(dx_q);
        sdy     = NUM_W'(dy_q);
        sv1x    = NUM_W'(v1x_q);
        sv1y    = NUM_W'(v1y_q);
        sv2x    = NUM_W'(v2x_q);
        sv2y    = NUM_W'(v2y_q);
        tx      = -sdy;
        ty      = sdx;
        p1      = sdx * sv1x + sdy * sv1y;
        p2      = sdx * sv2x + sdy * sv2y;
        t1      = tx * sv1x + ty * sv1y;
        t2      = tx * sv2x + ty * sv2y;
        numw[0] = sdx * p2 + tx * t1;
        numw[1] = sdy * p2 + ty * t1;
        numw[2] = sdx * p1 + tx * t2;
        numw[3] = sdy * p1 + ty * t2;
        n2_w    = sdx * sdx + sdy * sdy;
    end

    logic [NUM_W:0]   trial [4];
    logic [NUM_W-1:0] num_step [4];
    logic [NUM_W:0]   rem_step [4];

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            trial[d] = {rem_q[d][NUM_W-1:0], num_q[d][NUM_W-1]};
            if (trial[d] >= {1'b0, div_q}) begin
                rem_step[d] = trial[d] - {1'b0, div_q};
                num_step[d] = {num_q[d][NUM_W-2:0], 1'b1};
            end else begin
                rem_step[d] = trial[d];
                num_step[d] = {num_q[d][NUM_W-2:0], 1'b0};
            end
        end
    end

    function automatic logic signed [VEL_W-1:0] sat(input logic [NUM_W-1:0] mag, input logic neg);
        logic signed [NUM_W-1:0] v;
        v = neg ? -$signed(mag) : $signed(mag);
        if (v > VMAX)      sat = VMAX[VEL_W-1:0];
        else if (v < VMIN) sat = VMIN[VEL_W-1:0];
        else               sat = v[VEL_W-1:0];
    endfunction

    logic adv;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ci_d    = ci_q;
        cj_d    = cj_q;
        mask_d  = mask_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        v1x_d   = v1x_q;
        v1y_d   = v1y_q;
        v2x_d   = v2x_q;
        v2y_d   = v2y_q;
        div_d   = div_q;
        num_d   = num_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                vx_d = vel_in_x;
                vy_d = vel_in_y;
                if (startOfFrame) begin
                    state_d = S_SCAN;
                    k_d     = '0;
                    ci_d    = '0;
                    cj_d    = I_W'(1);
                    mask_d  = '0;
                end
            end
            S_SCAN: begin
                if (pending_q[k_q]) state_d = S_LOAD;
                else                adv     = 1'b1;
            end
            S_LOAD: begin
                dx_d    = $signed({1'b0, pos_x[cj_q]}) - $signed({1'b0, pos_x[ci_q]});
                dy_d    = $signed({1'b0, pos_y[cj_q]}) - $signed({1'b0, pos_y[ci_q]});
                v1x_d   = vx_q[ci_q];
                v1y_d   = vy_q[ci_q];
                v2x_d   = vx_q[cj_q];
                v2y_d   = vy_q[cj_q];
                state_d = S_MUL;
            end
            S_MUL: begin
                if (n2_w == '0) begin
                    adv = 1'b1;
                end else begin
                    for (int d = 0; d < 4; d++) begin
                        neg_d[d] = numw[d][NUM_W-1];
                        num_d[d] = numw[d][NUM_W-1] ? -numw[d] : numw[d];
                        rem_d[d] = '0;
                    end
                    div_d   = n2_w;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                num_d = num_step;
                rem_d = rem_step;
                cnt_d = cnt_q + C_W'(1);
                if (cnt_q == C_W'(NUM_W - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                vx_d[ci_q]   = sat(num_q[0], neg_q[0]);
                vy_d[ci_q]   = sat(num_q[1], neg_q[1]);
                vx_d[cj_q]   = sat(num_q[2], neg_q[2]);
                vy_d[cj_q]   = sat(num_q[3], neg_q[3]);
                mask_d[ci_q] = 1'b1;
                mask_d[cj_q] = 1'b1;
                adv          = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (k_q == K_W'(P - 1)) begin
                state_d = S_DONE;
            end else begin
                state_d = S_SCAN;
                k_d     = k_q + K_W'(1);
                if (cj_q == I_W'(NUM_BALLS - 1)) begin
                    ci_d = ci_q + I_W'(1);
                    cj_d = ci_q + I_W'(2);
                end else begin
                    cj_d = cj_q + I_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            ci_q      <= '0;
            cj_q      <= '0;
            armed_q   <= '1;
            pending_q <= '0;
            mask_q    <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            v1x_q     <= '0;
            v1y_q     <= '0;
            v2x_q     <= '0;
            v2y_q     <= '0;
            div_q     <= '0;
            neg_q     <= '0;
            cnt_q     <= '0;
            for (int b = 0; b < NUM_BALLS; b++) begin
                vx_q[b] <= '0;
                vy_q[b] <= '0;
            end
            for (int d = 0; d < 4; d++) begin
                num_q[d] <= '0;
                rem_q[d] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ci_q      <= ci_d;
            cj_q      <= cj_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            v1x_q     <= v1x_d;
            v1y_q     <= v1y_d;
            v2x_q     <= v2x_d;
            v2y_q     <= v2y_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
        end
    end

    assign collisionMask = mask_q;
    assign velValid      = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ball_collision_array.sv
// Directed bench for ball_collision_array (three balls): expected pass results are
// queued at frame start and checked by a monitor whenever velValid pulses.
module tb_ball_collision_array;
    localparam int N     = 3;
    localparam int CW    = 11;
    localparam int VW    = 11;
    localparam int P     = N * (N - 1) / 2;
    localparam int NUM_W = 2 * (CW + 1) + VW + 3;
    localparam int LAT_W = 16;
    localparam int EW    = 2 * N * VW + N + LAT_W;
    localparam int RES   = NUM_W + 3;

    logic              clk;
    logic              resetN;
    logic              startOfFrame;
    logic [N-1:0]      ballDR;
    logic [N*CW-1:0]   ballPosX, ballPosY;
    logic [N*VW-1:0]   ballVelX, ballVelY;
    logic [N*VW-1:0]   ballVelXOut, ballVelYOut;
    logic              velValid;
    logic [N-1:0]      collisionMask;
    logic              busy;

    ball_collision_array #(
        .NUM_BALLS(N), .COORD_W(CW), .VEL_W(VW), .BALL_DIAMETER(32)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
        .ballPosX(ballPosX), .ballPosY(ballPosY), .ballVelX(ballVelX), .ballVelY(ballVelY),
        .ballVelXOut(ballVelXOut), .ballVelYOut(ballVelYOut), .velValid(velValid),
        .collisionMask(collisionMask), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    logic signed [VW-1:0] ex_vx [N];
    logic signed [VW-1:0] ex_vy [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ball(input int b, input int x, input int y, input int vx, input int vy);
        ballPosX[b*CW +: CW] = CW'(x);
        ballPosY[b*CW +: CW] = CW'(y);
        ballVelX[b*VW +: VW] = VW'(vx);
        ballVelY[b*VW +: VW] = VW'(vy);
    endtask

    task automatic set_exp(input int b, input int vx, input int vy);
        ex_vx[b] = VW'(vx);
        ex_vy[b] = VW'(vy);
    endtask

    task automatic pulse_dr(input logic [N-1:0] m);
        ballDR = m;
        tick(1);
        ballDR = '0;
    endtask

    task automatic push_exp(input logic [N-1:0] mask, input int lat);
        logic [N*VW-1:0] px, py;
        for (int b = 0; b < N; b++) begin
            px[b*VW +: VW] = ex_vx[b];
            py[b*VW +: VW] = ex_vy[b];
        end
        exp_q.push_back({px, py, mask, LAT_W'(lat)});
    endtask

    task automatic start_pass();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            tick(1);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL pass_timeout: velValid not seen, %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    task automatic run_pass(input logic [N-1:0] mask, input int lat);
        push_exp(mask, lat);
        start_pass();
        wait_idle();
    endtask

    // monitor / scoreboard
    logic          prev_busy = 1'b0;
    int            cyc = 0;
    logic [EW-1:0] e;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) cyc = 1;
            else if (busy)          cyc++;
            prev_busy = busy;
            if (velValid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_velValid: actual=1 expected=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("velx_out", 64'(ballVelXOut), 64'(e[EW-1 -: N*VW]));
                    check("vely_out", 64'(ballVelYOut), 64'(e[EW-1-N*VW -: N*VW]));
                    check("collision_mask", 64'(collisionMask), 64'(e[LAT_W +: N]));
                    check("pass_latency", 64'(cyc), 64'(e[LAT_W-1:0]));
                end
            end
        end
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        ballDR       = '0;
        ballPosX     = '0;
        ballPosY     = '0;
        ballVelX     = '0;
        ballVelY     = '0;
        set_ball(0, 100, 100, 7, 3);
        set_ball(1, 300, 100, -5, 1);
        set_ball(2, 500, 500, 0, 0);
        tick(3);
        check("reset_velx", 64'(ballVelXOut), 64'd0);
        check("reset_vely", 64'(ballVelYOut), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(velValid), 64'd0);
        check("reset_mask", 64'(collisionMask), 64'd0);
        resetN = 1'b1;
        tick(2);

        // head-on along X, with a startOfFrame mid-pass that must be ignored
        set_ball(0, 100, 100, 4, 0);
        set_ball(1, 132, 100, -2, 0);
        tick(1);
        pulse_dr(3'b011);
        set_exp(0, -2, 0); set_exp(1, 4, 0); set_exp(2, 0, 0);
        push_exp(3'b011, 1 + P + RES);
        start_pass();
        tick(5);
        start_pass();
        wait_idle();

        // diagonal
        set_ball(0, 100, 100, 2, 0);
        set_ball(1, 116, 116, 0, 0);
        tick(1);
        pulse_dr(3'b011);
        set_exp(0, 1, -1); set_exp(1, 1, 1); set_exp(2, 0, 0);
        run_pass(3'b000 | 3'b011, 1 + P + RES);

        // coincident: n2 = 0, then no re-detection while still overlapping
        set_ball(1, 300, 100, 0, 0);
        tick(2);
        set_ball(0, 100, 100, 3, 1);
        set_ball(1, 100, 100, -1, 2);
        tick(1);
        pulse_dr(3'b011);
        set_exp(0, 3, 1); set_exp(1, -1, 2); set_exp(2, 0, 0);
        run_pass(3'b000, 1 + P + 2);
        pulse_dr(3'b011);
        run_pass(3'b000, 1 + P);

        // re-arm only after separation
        set_ball(1, 300, 100, 0, 0);
        tick(2);
        set_ball(0, 100, 100, 4, 0);
        set_ball(1, 120, 100, -2, 0);
        tick(1);
        pulse_dr(3'b011);
        set_exp(0, -2, 0); set_exp(1, 4, 0); set_exp(2, 0, 0);
        run_pass(3'b011, 1 + P + RES);
        pulse_dr(3'b011);
        set_exp(0, 4, 0); set_exp(1, -2, 0);
        run_pass(3'b000, 1 + P);
        set_ball(1, 140, 100, -2, 0);
        tick(2);
        set_ball(1, 120, 100, -2, 0);
        tick(1);
        pulse_dr(3'b011);
        set_exp(0, -2, 0); set_exp(1, 4, 0);
        run_pass(3'b011, 1 + P + RES);

        // chained resolution along a line
        set_ball(0, 100, 100, 4, 0);
        set_ball(1, 132, 100, 0, 0);
        set_ball(2, 164, 100, 0, 0);
        tick(2);
        pulse_dr(3'b011);
        pulse_dr(3'b110);
        set_exp(0, 0, 0); set_exp(1, 0, 0); set_exp(2, 4, 0);
        run_pass(3'b111, 1 + P + 2 * RES);

        // reset during the divide aborts the pass and clears pending pairs
        set_ball(2, 500, 500, 0, 0);
        set_ball(0, 100, 100, 5, 0);
        set_ball(1, 132, 100, 1, 0);
        tick(2);
        pulse_dr(3'b011);
        start_pass();
        tick(8);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_velx", 64'(ballVelXOut), 64'd0);
        check("midreset_vely", 64'(ballVelYOut), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_valid", 64'(velValid), 64'd0);
        check("midreset_mask", 64'(collisionMask), 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        tick(2);
        set_exp(0, 5, 0); set_exp(1, 1, 0); set_exp(2, 0, 0);
        run_pass(3'b000, 1 + P);

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
